char_text_typer: RTL and testbench
==================================

Name: char_text_typer

Overview:
Parametrised on-screen text source for the welcome, instruction and goodbye screens. Holds MSG_COUNT fixed messages on a COLS x ROWS character grid and returns the 7-bit character code for the grid cell requested by the text-drawing stage. It adds a registered output and a typewriter reveal: after a start pulse, characters appear one at a time, paced by a frame-rate tick. It sits between the game-stage control logic (msg_sel, start) and the font ROM / char-drawing pipeline (char_yx in, char_code out).

Parameters:
COLS, 16, characters per line (power of two)
ROWS, 16, lines per screen (power of two)
CHAR_W, 7, character code width (ASCII)
MSG_COUNT, 4, number of stored messages
RATE, 4, ticks per revealed character (>=1)
REVEAL, 1, 1 = typewriter reveal; 0 = whole message shown as soon as start is seen

Ports:
pclk  input  1  pixel clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
msg_sel  input  clog2(MSG_COUNT)  message index, sampled only on start
start  input  1  single-cycle pulse: latch msg_sel, restart reveal
tick  input  1  single-cycle pacing strobe (one per frame)
char_yx  input  clog2(ROWS)+clog2(COLS)  {line, column} of requested cell
char_code  output  CHAR_W  character for the cell, registered
char_valid  output  1  cell holds a revealed message character
typing  output  1  reveal in progress
done  output  1  whole message revealed

Behaviour:
- Reset (async, active-high): char_code=7'h20 (space), char_valid=0, typing=0, done=0, state IDLE, cnt=0, presc=0, latched msg=0.
- Cell index idx = line*COLS + column, width clog2(COLS*ROWS); no wrap, the grid maps linearly.
- Lookup latency 1 pclk: char_code/char_valid at cycle n+1 reflect char_yx at cycle n and the cnt value at cycle n.
- Lookup: if idx < cnt and idx < len[msg]: char_code = text[msg][idx], char_valid=1; otherwise char_code=7'h20, char_valid=0.
- FSM states IDLE, TYPING, DONE:
  - IDLE: cnt=0, so the screen is blank. start -> TYPING (REVEAL=1), or -> DONE with cnt=len (REVEAL=0).
  - TYPING: on tick, presc++. When presc==RATE-1 with tick set: presc=0 and cnt++. When cnt reaches len: go to DONE.
  - DONE: cnt held at len. start restarts as in IDLE.
- start in any state (including mid-TYPING) latches msg_sel and clears cnt and presc. start and tick in the same cycle: start wins and the tick is dropped.
- A msg_sel change without start has no effect.
- Zero-length message: start goes directly to DONE.
- Outputs: typing = (state==TYPING); done = (state==DONE). Both are registered and change in the cycle after the causing event.
- cnt saturates at len and never exceeds COLS*ROWS. Message text longer than the grid is truncated at build time.

Decomposition:
- Package char_text_pkg holds:
  - the state enum (IDLE/TYPING/DONE)
  - CHAR_SPACE = 7'h20
  - message text constants and the per-message length table
  - msg 0 = "Congratulations! You won!" (25 characters)
  - msg 1 = welcome/instructions text
- One sub-module, char_text_store: a purely combinational lookup (msg, idx) -> code, len. The reveal FSM, prescaler and output register stay in char_text_typer.

Test Plan:
- Reset mid-TYPING (cnt=7) -> next edge: char_code=7'h20, char_valid=0, typing=0, done=0. After release the screen is blank until start.
- msg_sel=0, RATE=4, start, then 8 ticks -> cnt=2. Reads of cells (0,0) and (0,1) return 'C' and 'o' with valid=1. Cell (0,2) returns 7'h20 with valid=0. Output lags char_yx by exactly 1 pclk.
- msg_sel=0, RATE=1, 25 ticks -> done=1 on the cycle after the 25th tick. Cell (1,8) (idx 24) returns '!'. Idx 25 onward returns space with valid=0. Extra ticks leave cnt at 25.
- start and tick asserted together in TYPING at cnt=10 -> cnt=0, presc=0, and the tick is not counted.
- REVEAL=0, msg_sel=1, start -> done=1 the next cycle and all message cells are readable immediately. Changing msg_sel without start leaves the output unchanged.
- Zero-length message (or start with the index of an empty slot) -> DONE in one cycle and all cells read space.

Source files
------------

// File: rtl/char_text_pkg.sv
// char_text_pkg: reveal states, message text table and length helper for char_text_typer.
package char_text_pkg;
  typedef enum logic [1:0] {IDLE, TYPING, DONE} state_t;
  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam int MSG_NUM = 4;
  localparam int MSG_MAX = 32;
  localparam int TW = 8 * MSG_MAX;
  // Literals are right-aligned in the vector: char i of a length-L message sits at byte L-1-i.
  localparam logic [TW-1:0] MSG_TEXT [MSG_NUM] = '{
    TW'("Congratulations! You won!"),
    TW'("Welcome! Use arrows to move."),
    TW'("Goodbye!"),
    TW'(0)
  };
  localparam int MSG_LEN [MSG_NUM] = '{25, 28, 8, 0};
  function automatic int msg_len(input int m, input int grid);
    if (m < 0 || m >= MSG_NUM) return 0;
    return (MSG_LEN[m] < grid) ? MSG_LEN[m] : grid;
  endfunction
endpackage

// File: rtl/char_text_store.sv
// char_text_store: combinational (msg, idx) -> character code and grid-truncated message length.
module char_text_store
  import char_text_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int CHAR_W = 7,
  parameter int MSG_COUNT = 4,
  localparam int MW = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
  localparam int IW = $clog2(COLS * ROWS),
  localparam int LW = IW + 1
) (
  input  logic [MW-1:0]     msg,
  input  logic [IW-1:0]     idx,
  output logic [CHAR_W-1:0] code,
  output logic [LW-1:0]     len
);
  int m, l, i, b;
  always_comb begin
    m = int'(msg);
    i = int'(idx);
    l = msg_len(m, COLS * ROWS);
    b = (i < l) ? 8 * (l - 1 - i) : 0;
    len = LW'(l);
    code = (i < l) ? CHAR_W'(MSG_TEXT[(m < MSG_NUM) ? m : 0][b +: 8]) : CHAR_W'(CHAR_SPACE);
  end
endmodule

// File: rtl/char_text_typer.sv
// char_text_typer: registered message character lookup with tick-paced typewriter reveal.
module char_text_typer
  import char_text_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int CHAR_W = 7,
  parameter int MSG_COUNT = 4,
  parameter int RATE = 4,
  parameter int REVEAL = 1,
  localparam int MW = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
  localparam int YW = $clog2(ROWS) + $clog2(COLS)
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [MW-1:0]     msg_sel,
  input  logic              start,
  input  logic              tick,
  input  logic [YW-1:0]     char_yx,
  output logic [CHAR_W-1:0] char_code,
  output logic              char_valid,
  output logic              typing,
  output logic              done
);
  localparam int IW = $clog2(COLS * ROWS);
  localparam int LW = IW + 1;
  localparam int PW = (RATE > 1) ? $clog2(RATE) : 1;
  state_t state;
  logic [LW-1:0] cnt, len, sel_len;
  logic [PW-1:0] presc;
  logic [MW-1:0] msg_q;
  logic [IW-1:0] idx;
  logic [CHAR_W-1:0] code;
  logic hit;
  // Power-of-two grid: {line, column} is already line*COLS + column.
  assign idx = char_yx;
  assign sel_len = LW'(msg_len(int'(msg_sel), COLS * ROWS));
  assign hit = ({1'b0, idx} < cnt) && ({1'b0, idx} < len);
  char_text_store #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .MSG_COUNT(MSG_COUNT)
  ) u_store (
    .msg(msg_q), .idx(idx), .code(code), .len(len)
  );
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      presc <= '0;
      msg_q <= '0;
      char_code <= CHAR_W'(CHAR_SPACE);
      char_valid <= 1'b0;
      typing <= 1'b0;
      done <= 1'b0;
    end else begin
      char_code <= hit ? code : CHAR_W'(CHAR_SPACE);
      char_valid <= hit;
      if (start) begin
        msg_q <= msg_sel;
        presc <= '0;
        cnt <= (REVEAL != 0) ? '0 : sel_len;
        if (REVEAL != 0 && sel_len != '0) begin
          state <= TYPING;
          typing <= 1'b1;
          done <= 1'b0;
        end else begin
          state <= DONE;
          typing <= 1'b0;
          done <= 1'b1;
        end
      end else if (state == TYPING && tick) begin
        if (presc == PW'(RATE - 1)) begin
          presc <= '0;
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == len) begin
            state <= DONE;
            typing <= 1'b0;
            done <= 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_char_text_typer.sv
// tb_char_text_typer: scoreboard bench over three configurations (RATE=4, RATE=1, REVEAL=0).
module tb_char_text_typer;
  typedef struct packed {
    logic [1:0] k;
    logic [6:0] code;
    logic v, t, d;
  } exp_t;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] msg_sel [3];
  logic start [3];
  logic tick [3];
  logic [7:0] yx [3];
  logic [6:0] cc [3];
  logic cv [3], ty [3], dn [3];
  logic rd = 1'b0;
  exp_t eq [$];
  string nq [$];
  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  char_text_typer #(.RATE(4), .REVEAL(1)) dut0 (
    .pclk(pclk), .rst(rst), .msg_sel(msg_sel[0]), .start(start[0]), .tick(tick[0]),
    .char_yx(yx[0]), .char_code(cc[0]), .char_valid(cv[0]), .typing(ty[0]), .done(dn[0]));
  char_text_typer #(.RATE(1), .REVEAL(1)) dut1 (
    .pclk(pclk), .rst(rst), .msg_sel(msg_sel[1]), .start(start[1]), .tick(tick[1]),
    .char_yx(yx[1]), .char_code(cc[1]), .char_valid(cv[1]), .typing(ty[1]), .done(dn[1]));
  char_text_typer #(.RATE(4), .REVEAL(0)) dut2 (
    .pclk(pclk), .rst(rst), .msg_sel(msg_sel[2]), .start(start[2]), .tick(tick[2]),
    .char_yx(yx[2]), .char_code(cc[2]), .char_valid(cv[2]), .typing(ty[2]), .done(dn[2]));

  exp_t e;
  string nm;
  logic [9:0] got;
  always @(posedge pclk) begin
    if (rd) begin
      #1;
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        e = eq.pop_front();
        nm = nq.pop_front();
        got = {cc[e.k], cv[e.k], ty[e.k], dn[e.k]};
        if (got !== {e.code, e.v, e.t, e.d}) begin
          errors++;
          $display("FAIL %s: got code=%h valid=%b typing=%b done=%b, want code=%h valid=%b typing=%b done=%b",
                   nm, got[9:3], got[2], got[1], got[0], e.code, e.v, e.t, e.d);
        end
      end
    end
  end

  task automatic step();
    @(negedge pclk);
    rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      tick[k] = 1'b0;
    end
  endtask

  task automatic go(input int k, input int m);
    msg_sel[k] = 2'(m);
    start[k] = 1'b1;
    step();
  endtask

  task automatic ticks(input int k, input int n);
    repeat (n) begin
      tick[k] = 1'b1;
      step();
    end
  endtask

  task automatic rdc(input int k, input int line, input int col, input logic [7:0] c,
                     input logic v, input logic t, input logic d, input string n);
    exp_t x;
    yx[k] = 8'((line << 4) | col);
    x.k = 2'(k);
    x.code = c[6:0];
    x.v = v;
    x.t = t;
    x.d = d;
    eq.push_back(x);
    nq.push_back(n);
    rd = 1'b1;
    step();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      msg_sel[k] = '0;
      start[k] = 1'b0;
      tick[k] = 1'b0;
      yx[k] = '0;
    end
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    step();
    rdc(0, 0, 0, 8'h20, 0, 0, 0, "reset_blank");
    go(0, 0);
    ticks(0, 8);
    rdc(0, 0, 0, "C", 1, 1, 0, "cell00");
    rdc(0, 0, 1, "o", 1, 1, 0, "cell01");
    rdc(0, 0, 2, 8'h20, 0, 1, 0, "cell02_hidden");
    ticks(0, 20);
    rst = 1'b1;
    rdc(0, 0, 0, 8'h20, 0, 0, 0, "reset_mid_typing");
    rst = 1'b0;
    rdc(0, 0, 0, 8'h20, 0, 0, 0, "post_reset_blank");
    go(1, 0);
    ticks(1, 24);
    rdc(1, 1, 8, 8'h20, 0, 1, 0, "idx24_before_last_tick");
    ticks(1, 1);
    rdc(1, 1, 8, "!", 1, 0, 1, "idx24_done");
    rdc(1, 1, 9, 8'h20, 0, 0, 1, "idx25_beyond");
    ticks(1, 5);
    rdc(1, 1, 8, "!", 1, 0, 1, "idx24_saturated");
    rdc(1, 1, 9, 8'h20, 0, 0, 1, "idx25_saturated");
    go(1, 0);
    ticks(1, 10);
    rdc(1, 0, 9, "a", 1, 1, 0, "cnt10_idx9");
    rdc(1, 0, 10, 8'h20, 0, 1, 0, "cnt10_idx10");
    msg_sel[1] = 2'd0;
    start[1] = 1'b1;
    tick[1] = 1'b1;
    step();
    rdc(1, 0, 0, 8'h20, 0, 1, 0, "start_tick_clears");
    ticks(1, 1);
    rdc(1, 0, 0, "C", 1, 1, 0, "after_one_tick");
    rdc(1, 0, 1, 8'h20, 0, 1, 0, "tick_was_dropped");
    go(2, 1);
    rdc(2, 0, 0, "W", 1, 0, 1, "noreveal_first");
    rdc(2, 1, 11, ".", 1, 0, 1, "noreveal_last");
    rdc(2, 1, 12, 8'h20, 0, 0, 1, "noreveal_beyond");
    msg_sel[2] = 2'd0;
    rdc(2, 0, 0, "W", 1, 0, 1, "sel_without_start");
    go(2, 3);
    rdc(2, 0, 0, 8'h20, 0, 0, 1, "empty_noreveal");
    go(0, 3);
    rdc(0, 0, 0, 8'h20, 0, 0, 1, "empty_reveal");
    step();
    step();
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never presented, want 0", eq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
